// File: rtl/fpa_pkg.sv
// Shared definitions for the floating-point adder scheduler: slot states and
// single-precision field layout.
package fpa_pkg;

    localparam int FP_W      = 32;
    localparam int FP_SIGN   = 31;
    localparam int FP_EXP_HI = 30;
    localparam int FP_EXP_LO = 23;
    localparam int FP_MAN_HI = 22;
    localparam int FP_MAN_LO = 0;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_INFLIGHT,
        SLOT_DONE
    } slot_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] v);
        return v[FP_SIGN];
    endfunction

endpackage

// File: rtl/fpa_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo NREQ; one-hot or zero grant.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int TAGW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        logic            found;
        logic [TAGW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // NREQ is a power of two, so TAGW-bit addition wraps naturally
            idx = ptr + TAGW'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_scheduler.sv
// Round-robin sharing of one pipelined FP adder among NREQ requesters with a
// private response slot each. Optional counters: FPA_SCHED_PERF_EN.
module fpa_scheduler
    import fpa_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = 3,
    localparam int TAGW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*FP_W-1:0] rsp_c,
    output logic [FP_W-1:0]      fpa_a,
    output logic [FP_W-1:0]      fpa_b,
    input  logic [FP_W-1:0]      fpa_c,
    output logic                 busy
`ifdef FPA_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    slot_e           st     [NREQ];
    slot_e           st_nxt [NREQ];
    logic [TAGW-1:0] ptr;
    logic [NREQ-1:0] idle_v;
    logic [NREQ-1:0] grant;
    logic [TAGW-1:0] gidx;
    logic            any_grant;

    // Stage 0 is aligned with the fpa_a/fpa_b register; stage LAT with fpa_c.
    logic [LAT:0]    pv;
    logic [TAGW-1:0] ptag [LAT+1];
    logic            ex_v;
    logic [TAGW-1:0] ex_tag;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            idle_v[i]    = (st[i] == SLOT_IDLE);
            rsp_valid[i] = (st[i] == SLOT_DONE);
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid & idle_v),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign any_grant = |req_ready;
    assign ex_v      = pv[LAT];
    assign ex_tag    = ptag[LAT];
    assign busy      = (|(~idle_v)) | (|pv);

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = TAGW'(i);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                SLOT_IDLE:     if (req_ready[i]) st_nxt[i] = SLOT_INFLIGHT;
                SLOT_INFLIGHT: if (ex_v && ex_tag == TAGW'(i)) st_nxt[i] = SLOT_DONE;
                SLOT_DONE:     if (rsp_ready[i]) st_nxt[i] = SLOT_IDLE;
                default:       st_nxt[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) st[i] <= SLOT_IDLE;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) st[i] <= st_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            pv    <= '0;
            fpa_a <= '0;
            fpa_b <= '0;
            rsp_c <= '0;
            for (int unsigned k = 0; k <= LAT; k++) ptag[k] <= '0;
        end else begin
            pv      <= {pv[LAT-1:0], any_grant};
            ptag[0] <= gidx;
            for (int unsigned k = 1; k <= LAT; k++) ptag[k] <= ptag[k-1];
            if (any_grant) begin
                ptr   <= gidx + TAGW'(1);
                fpa_a <= req_a[gidx*FP_W +: FP_W];
                fpa_b <= req_b[gidx*FP_W +: FP_W];
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (st[i] == SLOT_INFLIGHT && ex_v && ex_tag == TAGW'(i))
                    rsp_c[i*FP_W +: FP_W] <= fpa_c;
            end
        end
    end

`ifdef FPA_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (any_grant) perf_issued <= perf_issued + 32'd1;
            if (|(req_valid & ~idle_v)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpa_scheduler.sv
// Directed-vector bench for fpa_scheduler with a per-requester countdown model
// and a stand-in adder; define FPA_SCHED_PERF_EN to also check the counters.
module tb_fpa_scheduler;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [NREQ*32-1:0] rsp_c;
    logic [31:0]       fpa_a, fpa_b, fpa_c;
    logic              busy;
`ifdef FPA_SCHED_PERF_EN
    logic [31:0]       perf_issued, perf_stall;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    fpa_scheduler #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_c       (rsp_c),
        .fpa_a       (fpa_a),
        .fpa_b       (fpa_b),
        .fpa_c       (fpa_c),
        .busy        (busy)
`ifdef FPA_SCHED_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact for 1.0+2.0, otherwise an arbitrary fixed mixing.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h0001_0203;
    endfunction

    logic [31:0] dl [LAT] = '{default: '0};
    always @(posedge clk) begin
        dl[0] <= fadd(fpa_a, fpa_b);
        for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
    end
    assign fpa_c = dl[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each requester is idle, waiting out a countdown, or holding a result.
    int unsigned m_st  [NREQ];
    int unsigned m_cnt [NREQ];
    logic [31:0] m_val [NREQ];
    logic [31:0] m_rspc[NREQ];
    int unsigned m_ptr;
    logic [31:0] m_fa, m_fb;
    int unsigned m_issued, m_stall;

    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] er, ev;
        logic eb, stall;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                m_st[i] = 0; m_cnt[i] = 0; m_rspc[i] = '0;
            end
            m_ptr = 0; m_fa = '0; m_fb = '0; m_issued = 0; m_stall = 0;
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_fpa_a", fpa_a, 32'h0);
            chk("rst_fpa_b", fpa_b, 32'h0);
            for (int i = 0; i < NREQ; i++) chk("rst_rsp_c", rsp_c[i*32 +: 32], 32'h0);
`ifdef FPA_SCHED_PERF_EN
            chk("rst_perf_issued", perf_issued, 32'h0);
            chk("rst_perf_stall", perf_stall, 32'h0);
`endif
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[i] && m_st[i] == 0) g = i;
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            ev = '0;
            eb = 1'b0;
            stall = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                ev[i] = (m_st[i] == 2);
                if (m_st[i] != 0) eb = 1'b1;
                if (req_valid[i] && m_st[i] != 0) stall = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("busy", 32'(busy), 32'(eb));
            chk("fpa_a", fpa_a, m_fa);
            chk("fpa_b", fpa_b, m_fb);
            for (int i = 0; i < NREQ; i++)
                if (m_st[i] == 2) chk("rsp_c", rsp_c[i*32 +: 32], m_rspc[i]);
`ifdef FPA_SCHED_PERF_EN
            chk("perf_issued", perf_issued, m_issued);
            chk("perf_stall", perf_stall, m_stall);
`endif
            for (int i = 0; i < NREQ; i++) begin
                if (m_st[i] == 1) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_st[i] = 2;
                        m_rspc[i] = m_val[i];
                    end
                end else if (m_st[i] == 2 && rsp_ready[i]) begin
                    m_st[i] = 0;
                end
            end
            if (g >= 0) begin
                m_st[g]  = 1;
                m_cnt[g] = LAT + 1;
                m_fa     = req_a[g*32 +: 32];
                m_fb     = req_b[g*32 +: 32];
                m_val[g] = fadd(m_fa, m_fb);
                m_ptr    = (g + 1) % NREQ;
                m_issued++;
            end
            if (stall) m_stall++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic wait_rsp(input int i, input string name);
        int n;
        n = 0;
        while (!rsp_valid[i] && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(rsp_valid[i]), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          others;

        do_reset();

        // Single requester: 1.0 + 2.0, four-cycle latency.
        set_op(0, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        #1 chk("s1_grant", 32'(req_ready), 32'h1);
        tick();
        chk("s1_ready_low", 32'(req_ready[0]), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("s1_no_rsp", 32'(rsp_valid[0]), 32'h0);
            chk("s1_ready_low", 32'(req_ready[0]), 32'h0);
        end
        tick();
        chk("s1_rsp_valid", 32'(rsp_valid[0]), 32'h1);
        chk("s1_rsp_c", rsp_c[31:0], 32'h4040_0000);
        chk("s1_ready_low", 32'(req_ready[0]), 32'h0);
        req_valid = '0;
        rsp_ready = 4'b0001;
        tick();
        chk("s1_rsp_done", 32'(rsp_valid[0]), 32'h0);
        rsp_ready = '0;

        // All four at once from ptr=0.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_op(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i << 4));
        req_valid = 4'b1111;
        #1 chk("s2_grant0", 32'(req_ready), 32'h1);
        for (int k = 1; k < NREQ; k++) begin
            tick();
            chk("s2_grant", 32'(req_ready), 32'(1 << k));
        end
        tick();
        chk("s2_all_busy", 32'(req_ready), 32'h0);
        for (int k = 0; k < NREQ; k++) begin
            tick();
            chk("s2_rsp_rise", 32'(rsp_valid), 32'((1 << (k + 1)) - 1));
        end
        req_valid = '0;
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = '0;

        // Fairness: after a grant to 2, requester 3 precedes 1.
        req_valid = 4'b0100;
        #1 chk("s3_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1010;
        #1 chk("s3_grant3", 32'(req_ready), 32'h8);
        tick();
        chk("s3_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        rsp_ready = '0;

        // Back-pressure on requester 1 while the others keep issuing.
        do_reset();
        set_op(1, 32'h4120_0000, 32'h3F00_0000);
        set_op(0, 32'h1111_1111, 32'h2222_2222);
        set_op(2, 32'h3333_3333, 32'h4444_4444);
        set_op(3, 32'h5555_5555, 32'h6666_6666);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_rsp(1, "s4_rsp_timeout");
        held = rsp_c[63:32];
        chk("s4_rsp_c", held, fadd(32'h4120_0000, 32'h3F00_0000));
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        others = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("s4_rsp_valid_held", 32'(rsp_valid[1]), 32'h1);
            chk("s4_ready1_low", 32'(req_ready[1]), 32'h0);
            chk("s4_rsp_c_stable", rsp_c[63:32], held);
            if (|(req_ready & 4'b1101)) others++;
            tick();
        end
        chk("s4_others_issue", 32'(others > 0), 32'h1);
        req_valid = '0;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        rsp_ready = '0;

`ifdef FPA_SCHED_PERF_EN
        // Ten stall cycles with requester 1 holding req_valid over a DONE slot.
        do_reset();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_rsp(1, "perf_rsp_timeout");
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) tick();
        chk("perf_stall_10", perf_stall, 32'd10);
        chk("perf_issued_1", perf_issued, 32'd1);
        req_valid = '0;
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = '0;
`endif

        // Reset two cycles after a grant discards the operation.
        do_reset();
        set_op(0, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("s5_ready_zero", 32'(req_ready), 32'h0);
        chk("s5_busy_zero", 32'(busy), 32'h0);
        chk("s5_fpa_a_zero", fpa_a, 32'h0);
        chk("s5_rsp_valid_zero", 32'(rsp_valid), 32'h0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            chk("s5_no_rsp", 32'(rsp_valid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fpa_scheduler.md
# fpa_scheduler

Shares one pipelined single-precision floating-point adder (`fpa`) among `NREQ` requesters. It arbitrates round-robin, issues at most one operation per cycle, and tags each operation through the adder pipeline. Each requester has a private response slot, so results return to the correct owner even under response back-pressure. The block sits between the integer/FP issue logic and the `fpa` instance in the execute stage.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; power of two, 2..8.
- `LAT`, default 3: adder latency in cycles from `fpa_a`/`fpa_b` to the matching `fpa_c`; must be ≥1.
- `TAGW`, default `$clog2(NREQ)`: width of the requester tag; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero.
- `req_a`  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B; same packing as `req_a`.
- `rsp_valid`  out  NREQ  per-requester result valid.
- `rsp_ready`  in  NREQ  per-requester result accept.
- `rsp_c`  out  NREQ*32  per-requester result; same packing as `req_a`.
- `fpa_a`  out  32  registered operand A to the adder.
- `fpa_b`  out  32  registered operand B to the adder.
- `fpa_c`  in  32  adder result.
- `busy`  out  1  high if any slot is not IDLE or any pipeline tag is valid.
- `perf_issued`  out  32  operations issued; present only with `FPA_SCHED_PERF_EN`.
- `perf_stall`  out  32  cycles lost to a busy slot; present only with `FPA_SCHED_PERF_EN`.

## Operation
Each requester has a slot FSM with three states:
- IDLE → INFLIGHT when that requester's handshake (`req_valid & req_ready`) completes.
- INFLIGHT → DONE on the edge where its tag exits the pipeline; `fpa_c` is captured into that slot's `rsp_c`.
- DONE → IDLE on `rsp_valid & rsp_ready`.

Arbitration:
- Eligible requesters: `req_valid[i]` high and slot i IDLE, evaluated on the current-cycle state.
- Round-robin pointer `ptr`: the search starts at `ptr` and wraps modulo `NREQ`. On a grant to requester g, `ptr` becomes (g+1) mod `NREQ`. With no grant, `ptr` holds.
- `req_ready` is combinational from `req_valid`, the slot states and `ptr`.

Issue pipeline:
- On a grant, `req_a`/`req_b` of the granted requester are registered into `fpa_a`/`fpa_b`. A valid+tag entry is pushed into a `LAT`-deep shift register.
- With no grant, `fpa_a`/`fpa_b` hold their last values and a zero-valid entry is pushed.

Response and data handling:
- `rsp_c[i]` is stable while `rsp_valid[i]` is high.
- `rsp_valid[i]` is high exactly while slot i is DONE.
- Data passes through unmodified; the block does no rounding or special-case handling.

Simultaneous and boundary events:
- Response handshake and a new request from the same requester in the same cycle: not granted; the earliest grant is the next cycle.
- All slots busy: `req_ready` = 0 and the pipeline idles.

Reset (at power-up or mid-operation):
- All slots IDLE, `ptr` = 0, all pipeline valid bits 0.
- `fpa_a` = `fpa_b` = 0, `rsp_c` = 0, `req_ready` = 0, `rsp_valid` = 0, `busy` = 0, perf counters = 0.
- In-flight operations are discarded; adder outputs that arrive afterwards are ignored.

## Timing
- Handshake at edge E → `fpa_a`/`fpa_b` valid during cycle E+1 → `fpa_c` captured at edge E+1+`LAT` → `rsp_valid` high after that edge.
- Acceptance to response is `LAT`+1 cycles; 4 with defaults.
- Throughput: 1 issue per cycle across requesters; 1 outstanding operation per requester.
- Earliest re-issue for the same requester is 1 cycle after its response handshake, giving per-requester occupancy of `LAT`+2 cycles.

## Configuration
- `FPA_SCHED_PERF_EN` defined:
  - `perf_issued` increments on every grant.
  - `perf_stall` increments on every cycle in which some `req_valid[i]` is high while slot i is not IDLE.
  - Both wrap at 2^32 and clear on `rst`.
- Undefined: neither port exists and the counter logic is removed.

## Structure
- Shared package `fpa_pkg`:
  - slot-state enum (IDLE, INFLIGHT, DONE);
  - `FP_W` = 32;
  - field constants for sign [31], exponent [30:23] and mantissa [22:0].
- One sub-module `rr_arbiter` (`NREQ` request vector plus `ptr` in, one-hot grant out, combinational). The pointer register lives in `fpa_scheduler`.

## Test plan
- Single requester: requester 0 sends a=0x3F800000 (1.0), b=0x40000000 (2.0) at edge 0 → `rsp_valid[0]` high after edge 4 with `rsp_c[0]` = 0x40400000 (3.0); `req_ready[0]` stays low until after the response handshake.
- All four assert `req_valid` together, `ptr`=0 → grants to 0, 1, 2, 3 at edges 0..3; `rsp_valid` rises after edges 4, 5, 6, 7 respectively.
- Fairness: only requester 2 is granted, then requesters 1 and 3 request → requester 3 is granted before requester 1.
- Back-pressure: `rsp_ready[1]` held low for 10 cycles → `rsp_c[1]` stable, `rsp_valid[1]` stays high, `req_ready[1]` = 0 throughout, and other requesters keep issuing.
- Reset mid-flight: assert `rst` 2 cycles after a grant → all outputs 0 and `busy`=0 immediately; no `rsp_valid` after reset is released.
- With `FPA_SCHED_PERF_EN`: the back-pressure scenario with `req_valid[1]` held high → `perf_stall` = 10, and `perf_issued` equals the number of grants.
